// File: rtl/base_unpacker_if.sv
// base_unpacker_if
//   Handshake bundle for the base unpacker: a packed-word input stream and
//   a one-base-per-beat output stream. clk/rst_n are separate plain ports
//   on the design and are not carried here.
//
//   Signals:
//     in_data   packed word, first base in the top two bits
//     in_valid  in_data/in_last/in_count are valid
//     in_ready  unpacker accepts a word this cycle
//     in_last   word is the final word of the sequence
//     in_count  number of valid bases in a last word
//     out_base  2-bit base code (0=A, 1=C, 2=T, 3=G)
//     out_valid out_base is valid
//     out_ready downstream consumes out_base this cycle
//     out_last  out_base is the final base of the sequence
//
//   Modports:
//     slave  - the unpacker side
//     master - the environment side (upstream source + downstream sink)
interface base_unpacker_if #(
  parameter int BASES_PER_WORD = 4,
  parameter int CNT_W          = 3
);
  logic [2*BASES_PER_WORD-1:0] in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic                        in_last;
  logic [CNT_W-1:0]            in_count;
  logic [1:0]                  out_base;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_last;

  modport slave (
    input  in_data, in_valid, in_last, in_count, out_ready,
    output in_ready, out_base, out_valid, out_last
  );

  modport master (
    output in_data, in_valid, in_last, in_count, out_ready,
    input  in_ready, out_base, out_valid, out_last
  );
endinterface

// File: rtl/base_unpacker.sv
// base_unpacker
//   Splits packed genome words (BASES_PER_WORD 2-bit codes, first base in
//   the top bits) into a stream of one base per cycle for the downstream
//   2-bit-to-ASCII decoder. A final word may be partial (in_last/in_count).
//
//   Ports:
//     clk         rising-edge clock
//     rst_n       asynchronous active-low reset
//     bus         base_unpacker_if.slave handshake bundle
//     base_count  (only with BASE_UNPACKER_COUNT_EN) 32-bit count of output
//                 transfers in the current sequence
//
//   Optional feature macro: BASE_UNPACKER_COUNT_EN
module base_unpacker #(
  parameter int BASES_PER_WORD = 4,
  parameter int CNT_W          = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  base_unpacker_if.slave  bus
`ifdef BASE_UNPACKER_COUNT_EN
  ,
  output logic [31:0]     base_count
`endif
);

  localparam int W = 2 * BASES_PER_WORD;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BASES_PER_WORD);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  // The state is purely a view of the remaining-base counter.
  typedef enum logic {
    EMPTY,
    ACTIVE
  } state_t;

  state_t           state;
  logic [W-1:0]     sh, sh_nxt;
  logic [CNT_W-1:0] rem, rem_nxt;
  logic             lst, lst_nxt;
  logic [CNT_W-1:0] load_cnt;
  logic             in_xfer, out_xfer;

  assign state = (rem == '0) ? EMPTY : ACTIVE;

  // A new word may be taken while the last base of the current one is
  // being consumed, which keeps the output stream gap-free across words.
  assign bus.in_ready  = (state == EMPTY) || ((rem == ONE) && bus.out_ready);
  assign bus.out_base  = sh[W-1:W-2];
  assign bus.out_valid = (state == ACTIVE);
  assign bus.out_last  = lst && (rem == ONE);

  assign in_xfer  = bus.in_valid && bus.in_ready;
  assign out_xfer = bus.out_valid && bus.out_ready;

  // A count of zero or one larger than a word is treated as a full word.
  always_comb begin
    load_cnt = FULL;
    if (bus.in_last && (bus.in_count != '0) && (bus.in_count <= FULL)) begin
      load_cnt = bus.in_count;
    end
  end

  // Load has priority: it can only coincide with draining the final base.
  always_comb begin
    sh_nxt  = sh;
    rem_nxt = rem;
    lst_nxt = lst;
    if (in_xfer) begin
      sh_nxt  = bus.in_data;
      rem_nxt = load_cnt;
      lst_nxt = bus.in_last;
    end else if (out_xfer) begin
      sh_nxt  = {sh[W-3:0], 2'b00};
      rem_nxt = rem - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh  <= '0;
      rem <= '0;
      lst <= 1'b0;
    end else begin
      sh  <= sh_nxt;
      rem <= rem_nxt;
      lst <= lst_nxt;
    end
  end

`ifdef BASE_UNPACKER_COUNT_EN
  // The count stays visible for one cycle after the final base, then clears.
  // If a new sequence already transfers in that clearing cycle, it counts 1.
  logic clr_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_count <= '0;
      clr_pend   <= 1'b0;
    end else begin
      clr_pend <= out_xfer && bus.out_last;
      if (clr_pend) begin
        base_count <= out_xfer ? 32'd1 : 32'd0;
      end else if (out_xfer) begin
        base_count <= base_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_base_unpacker.sv
// tb_base_unpacker
//   Directed scenarios for the base unpacker plus a randomized run scored
//   against a queue-of-bases reference model.
module tb_base_unpacker;

  localparam int N     = 4;
  localparam int CNT_W = 3;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  typedef struct packed {
    logic [1:0] b;
    logic       l;
  } ent_t;

  ent_t q[$];

  base_unpacker_if #(.BASES_PER_WORD(N), .CNT_W(CNT_W)) bus ();

`ifdef BASE_UNPACKER_COUNT_EN
  logic [31:0] base_count;
`endif

  base_unpacker #(.BASES_PER_WORD(N), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus)
`ifdef BASE_UNPACKER_COUNT_EN
    ,
    .base_count (base_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the upstream side; blocking, called just after a falling edge.
  task automatic set_in(input logic v, input logic [7:0] d, input logic l,
                        input logic [2:0] c, input logic r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.in_count  = c;
    bus.out_ready = r;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    checks++;
    if (bus.out_base !== 2'd0 || bus.out_last !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_base_last: got base=%0d last=%b expected 0/0",
                         bus.out_base, bus.out_last);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    int exp_b[4] = '{1, 3, 2, 0};
    @(negedge clk);
    set_in(1'b1, 8'b01_11_10_00, 1'b0, 3'd0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_base !== 2'(exp_b[i]) || bus.out_last !== 1'b0) begin
        errors++; $display("[TB] FAIL single_base[%0d]: got v=%b b=%0d l=%b expected v=1 b=%0d l=0",
                           i, bus.out_valid, bus.out_base, bus.out_last, exp_b[i]);
      end
      if (i == 3) begin
        checks++;
        if (bus.in_ready !== 1'b1) begin
          errors++; $display("[TB] FAIL single_in_ready_4th: got %b expected 1", bus.in_ready);
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL single_drained: got out_valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int exp_b[8] = '{0, 1, 2, 3, 3, 2, 1, 0};
    @(negedge clk);
    set_in(1'b1, 8'h1B, 1'b0, 3'd0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.in_data = 8'hE4;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_base !== 2'(exp_b[i])) begin
        errors++; $display("[TB] FAIL b2b_base[%0d]: got v=%b b=%0d expected v=1 b=%0d",
                           i, bus.out_valid, bus.out_base, exp_b[i]);
      end
      @(posedge clk);
      @(negedge clk);
      if (i == 3) bus.in_valid = 1'b0;
    end
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_drained: got out_valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_last_word();
    int exp_b[4] = '{3, 0, 0, 0};
    // In_Count=1: a single base carrying out_last.
    @(negedge clk);
    set_in(1'b1, 8'hC0, 1'b1, 3'd1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_base !== 2'd3 || bus.out_last !== 1'b1) begin
      errors++; $display("[TB] FAIL last_cnt1: got v=%b b=%0d l=%b expected v=1 b=3 l=1",
                         bus.out_valid, bus.out_base, bus.out_last);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin
      errors++; $display("[TB] FAIL last_cnt1_after: got v=%b l=%b expected 0/0",
                         bus.out_valid, bus.out_last);
    end
    // In_Count=0: a full word, out_last only on the fourth base.
    @(negedge clk);
    set_in(1'b1, 8'hC0, 1'b1, 3'd0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_base !== 2'(exp_b[i]) || bus.out_last !== (i == 3)) begin
        errors++; $display("[TB] FAIL last_cnt0[%0d]: got v=%b b=%0d l=%b expected v=1 b=%0d l=%b",
                           i, bus.out_valid, bus.out_base, bus.out_last, exp_b[i], (i == 3));
      end
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL last_cnt0_after: got out_valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_stall();
    int   exp_b[4] = '{1, 2, 3, 0};
    logic pat[9]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int   k = 0;
    @(negedge clk);
    set_in(1'b1, 8'h6C, 1'b0, 3'd0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int c = 0; c < 9; c++) begin
      bus.out_ready = pat[c];
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_base !== 2'(exp_b[k])) begin
        errors++; $display("[TB] FAIL stall_base[c%0d]: got v=%b b=%0d expected v=1 b=%0d",
                           c, bus.out_valid, bus.out_base, exp_b[k]);
      end
      if (k == 3 && !pat[c]) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          errors++; $display("[TB] FAIL stall_in_ready[c%0d]: got %b expected 0", c, bus.in_ready);
        end
      end
      if (pat[c]) k++;
      @(posedge clk);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL stall_drained: got out_valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int exp_a[2] = '{0, 1};
    int exp_b[4] = '{3, 2, 1, 0};
    @(negedge clk);
    set_in(1'b1, 8'h1B, 1'b0, 3'd0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (bus.out_base !== 2'(exp_a[i])) begin
        errors++; $display("[TB] FAIL rstmid_pre[%0d]: got %0d expected %0d", i, bus.out_base, exp_a[i]);
      end
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_base !== 2'd0 || bus.in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL rstmid_async: got v=%b b=%0d rdy=%b expected v=0 b=0 rdy=1",
                         bus.out_valid, bus.out_base, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1'b1, 8'hE4, 1'b0, 3'd0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_base !== 2'(exp_b[i])) begin
        errors++; $display("[TB] FAIL rstmid_post[%0d]: got v=%b b=%0d expected v=1 b=%0d",
                           i, bus.out_valid, bus.out_base, exp_b[i]);
      end
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL rstmid_drained: got out_valid=%b expected 0", bus.out_valid);
    end
  endtask

  // Reference model: accepted words become a queue of (base, last) entries;
  // the DUT's output must be the queue head and its readiness follows from
  // how many bases are still queued.
  task automatic test_random(input int ncyc);
    logic       v, la, r, ev, er;
    logic [7:0] d;
    logic [2:0] cnt;
    int         k;
    ent_t       e;
    q.delete();
    for (int c = 0; c < ncyc + 2 * N; c++) begin
      @(negedge clk);
      if (c < ncyc) begin
        v   = 1'($urandom_range(0, 1));
        d   = 8'($urandom);
        la  = ($urandom_range(0, 3) == 0);
        cnt = 3'($urandom_range(0, 7));
        r   = ($urandom_range(0, 3) != 0);
      end else begin
        v = 1'b0; d = 8'h00; la = 1'b0; cnt = 3'd0; r = 1'b1;
      end
      set_in(v, d, la, cnt, r);
      #1;
      ev = (q.size() != 0);
      er = (q.size() == 0) || (q.size() == 1 && r);
      checks++;
      if (bus.out_valid !== ev || bus.in_ready !== er) begin
        errors++; $display("[TB] FAIL rand_hs[c%0d]: got v=%b rdy=%b expected v=%b rdy=%b",
                           c, bus.out_valid, bus.in_ready, ev, er);
      end
      if (ev) begin
        checks++;
        if (bus.out_base !== q[0].b || bus.out_last !== q[0].l) begin
          errors++; $display("[TB] FAIL rand_data[c%0d]: got b=%0d l=%b expected b=%0d l=%b",
                             c, bus.out_base, bus.out_last, q[0].b, q[0].l);
        end
      end
      if (ev && r) void'(q.pop_front());
      if (v && er) begin
        k = (!la || cnt == 0 || cnt > N) ? N : int'(cnt);
        for (int j = 0; j < k; j++) begin
          e.b = d[7-2*j -: 2];
          e.l = la && (j == k - 1);
          q.push_back(e);
        end
      end
    end
  endtask

`ifdef BASE_UNPACKER_COUNT_EN
  task automatic test_counter();
    logic [7:0] w[4] = '{8'h1B, 8'hE4, 8'h6C, 8'hC0};
    int   idx = 0;
    int   xfers = 0;
    logic seen_last = 1'b0;
    logic acc, ov, ol;
    @(negedge clk);
    rst_n = 1'b0;
    set_in(1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (base_count !== 32'd0) begin
      errors++; $display("[TB] FAIL count_reset: got %0d expected 0", base_count);
    end
    for (int c = 0; c < 40 && !seen_last; c++) begin
      if (idx < 4) set_in(1'b1, w[idx], (idx == 3), 3'd2, 1'b1);
      else         set_in(1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
      #1;
      acc = bus.in_valid && bus.in_ready;
      ov  = bus.out_valid;
      ol  = bus.out_last;
      @(posedge clk);
      @(negedge clk);
      if (acc) idx++;
      if (ov) begin
        xfers++;
        if (ol) seen_last = 1'b1;
      end
    end
    #1;
    checks++;
    if (!seen_last || xfers != 14) begin
      errors++; $display("[TB] FAIL count_seq: got last_seen=%b xfers=%0d expected 1/14", seen_last, xfers);
    end
    checks++;
    if (base_count !== 32'd14) begin
      errors++; $display("[TB] FAIL count_peak: got %0d expected 14", base_count);
    end
    @(negedge clk);
    #1;
    checks++;
    if (base_count !== 32'd0) begin
      errors++; $display("[TB] FAIL count_clear: got %0d expected 0", base_count);
    end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_last_word();
    test_stall();
    test_reset_mid();
    test_random(600);
`ifdef BASE_UNPACKER_COUNT_EN
    test_counter();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/base_unpacker.md
Name: base_unpacker

Overview:
- Upstream neighbour of the 2-bit-code-to-ASCII decoder stage in the decompression path.
- Accepts packed genome words, BASES_PER_WORD 2-bit base codes per word, over a valid/ready handshake.
- Emits one 2-bit base code per cycle, MSB-first, over a valid/ready handshake that feeds the decoder's 2-bit input.
- Supports a partial final word through In_Last/In_Count.

Parameters:
- BASES_PER_WORD, 4: bases packed per input word. Must be ≥2. Word width = 2*BASES_PER_WORD.
- CNT_W, 3: width of In_Count. Must be ≥ clog2(BASES_PER_WORD)+1.

Ports:
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous active-low reset.
- In_Data  in  2*BASES_PER_WORD  packed word. Bits [2N-1:2N-2] hold the first base.
- In_Valid  in  1  In_Data/In_Last/In_Count are valid.
- In_Ready  out  1  block accepts a word this cycle.
- In_Last  in  1  word is the final word of the sequence.
- In_Count  in  CNT_W  number of valid bases in the last word. Sampled only when In_Last=1.
- Out_Base  out  2  base code: 0=A, 1=C, 2=T, 3=G.
- Out_Valid  out  1  Out_Base is valid.
- Out_Ready  in  1  downstream consumes Out_Base this cycle.
- Out_Last  out  1  Out_Base is the final base of the sequence.

Behaviour:
- Handshakes:
  - An input transfer occurs when In_Valid & In_Ready at a rising Clk edge.
  - An output transfer occurs when Out_Valid & Out_Ready at a rising Clk edge.
  - While Out_Valid=1 and Out_Ready=0, Out_Base, Out_Valid and Out_Last hold stable.
- Storage:
  - Shift register sh (2N bits).
  - Remaining-base counter rem (CNT_W bits).
  - Last flag lst.
- Outputs:
  - Out_Base = sh[2N-1:2N-2].
  - Out_Valid = (rem != 0).
  - Out_Last = lst & (rem == 1).
- States: EMPTY (rem==0) and ACTIVE (rem>0). State is derived from rem; no separate state register.
- In_Ready = (rem==0) | (rem==1 & Out_Ready). This is combinational from Out_Ready and sustains one base per cycle across word boundaries.
- Input load (input transfer occurs):
  - sh ← In_Data.
  - rem ← N if In_Last=0. If In_Last=1: rem ← In_Count, except In_Count=0 or In_Count>N gives rem ← N.
  - lst ← In_Last.
- Output transfer without load: sh ← sh << 2, zero fill. rem ← rem−1.
- Simultaneous last-base consume and load: the load wins. The new word's first base appears on the next cycle with no bubble.
- Latency: first base valid 1 cycle after the input transfer. A full word drains in N cycles when Out_Ready stays high.
- Reset (async assert, any time including mid-word):
  - sh=0, rem=0, lst=0.
  - Out_Valid=0, Out_Last=0, Out_Base=0, In_Ready=1.
  - A partially emitted word is discarded.
  - Reset deassertion is synchronised by the system; no internal synchroniser.
- No combinational path from In_Valid to Out_Valid.

Optional Feature:
- Macro BASE_UNPACKER_COUNT_EN.
- When defined:
  - Extra output port Base_Count, out, 32 bits.
  - Counts output transfers. Resets to 0 on Reset_n.
  - Wraps from 0xFFFFFFFF to 0.
  - Clears to 0 on the cycle after an output transfer with Out_Last=1, so each sequence is counted from 0.
- When undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- N=4, single word 8'b01_11_10_00 with In_Last=0, Out_Ready=1 → Out_Base 1,3,2,0 (C,G,T,A) on 4 consecutive cycles. Out_Last=0 throughout. In_Ready=1 on the 4th base.
- Back-to-back words 8'h1B, 8'hE4, In_Valid held high, Out_Ready=1 → 8 consecutive bases 0,1,2,3,3,2,1,0 with no bubble.
- Last word 8'hC0 with In_Last=1, In_Count=1 → a single base 3 with Out_Last=1, then Out_Valid=0. In_Count=0 → 4 bases, Out_Last on the 4th.
- Out_Ready toggled 1,0,0,1,… on word 8'h6C → Out_Base holds during stalls. Order remains 1,2,3,0. In_Ready=0 while stalled on the last base.
- Reset_n pulsed low after 2 of 4 bases are emitted → Out_Valid=0 immediately (async). The remaining 2 bases are never emitted. The next word emits from its first base.
- With BASE_UNPACKER_COUNT_EN: 3 full words then a last word with In_Count=2 → Base_Count reaches 14, then reads 0 on the cycle after the Out_Last transfer.
